// File: rtl/hub75_scan_scheduler_if.sv
// HUB75 scan scheduler bus: frame control, column-shifter handshake and panel strobes.
// master = scheduler side, slave = controller/shifter/panel side.
interface hub75_scan_scheduler_if #(
  parameter int SCAN_RATE  = 32,
  parameter int BIT_DEPTH  = 3,
  parameter int THETA_BITS = 10
);
  localparam int ROW_W = $clog2(SCAN_RATE);
  localparam int PL_W  = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;

  logic                  enable;
  logic [THETA_BITS-1:0] dtheta;
  logic                  shift_done;
  logic                  shift_start;
  logic [ROW_W-1:0]      row_addr;
  logic [PL_W-1:0]       bit_plane;
  logic                  latch;
  logic                  oe_n;
  logic                  frame_done;
  logic                  busy;

  modport master (
    input  enable, dtheta, shift_done,
    output shift_start, row_addr, bit_plane, latch, oe_n, frame_done, busy
  );

  modport slave (
    output enable, dtheta, shift_done,
    input  shift_start, row_addr, bit_plane, latch, oe_n, frame_done, busy
  );
endinterface

// File: rtl/hub75_scan_scheduler.sv
// HUB75 row/bit-plane scan scheduler with binary-coded-modulation on-times.
// Optional feature: define HUB75_SCAN_DEADTIME_EN to insert a 2-cycle
// blanked DEAD state between LATCH and DISPLAY.
module hub75_scan_scheduler #(
  parameter int SCAN_RATE      = 32,
  parameter int BIT_DEPTH      = 3,
  parameter int BASE_ON_CYCLES = 16,
  parameter int THETA_BITS     = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  hub75_scan_scheduler_if.master bus
);
  localparam int ROW_W = $clog2(SCAN_RATE);
  localparam int PL_W  = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
  localparam int CNT_W = $clog2((BASE_ON_CYCLES << (BIT_DEPTH - 1)) + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SCAN_RATE - 1);
  localparam logic [PL_W-1:0]  PL_LAST  = PL_W'(BIT_DEPTH - 1);

`ifdef HUB75_SCAN_DEADTIME_EN
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_BLANK, S_LATCH, S_DEAD, S_DISPLAY} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY} state_t;
`endif

  state_t                r_state, w_state_nxt;
  logic [THETA_BITS-1:0] r_theta;
  logic [ROW_W-1:0]      r_row, r_row_addr;
  logic [PL_W-1:0]       r_plane, r_bit_plane;
  logic [CNT_W-1:0]      r_cnt, w_on_len;
  logic                  r_restart;
  logic                  r_shift_start, r_latch, r_oe_n, r_frame_done, r_busy;
  logic                  w_shift_start_d, w_latch_d, w_oe_n_d, w_frame_done_d, w_busy_d;
  logic                  w_start, w_disp_end, w_plane_last, w_frame_end;
`ifdef HUB75_SCAN_DEADTIME_EN
  logic                  r_dead;
`endif

  assign w_start      = (r_state == S_IDLE) && bus.enable;
  assign w_disp_end   = (r_state == S_DISPLAY) && (r_cnt == '0);
  assign w_plane_last = (r_plane == PL_LAST);
  // Restart requests are only honoured at a row wrap so no row is torn.
  assign w_frame_end  = w_disp_end && w_plane_last && ((r_row == ROW_LAST) || r_restart);
  assign w_on_len     = CNT_W'(BASE_ON_CYCLES) << r_plane;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.enable) w_state_nxt = S_SHIFT;
      // A shift_done coinciding with our own shift_start belongs to an older request.
      S_SHIFT:   if (bus.shift_done && !r_shift_start) w_state_nxt = S_BLANK;
      S_BLANK:   w_state_nxt = S_LATCH;
`ifdef HUB75_SCAN_DEADTIME_EN
      S_LATCH:   w_state_nxt = S_DEAD;
      S_DEAD:    if (r_dead) w_state_nxt = S_DISPLAY;
`else
      S_LATCH:   w_state_nxt = S_DISPLAY;
`endif
      S_DISPLAY: if (w_disp_end) w_state_nxt = (w_frame_end && !bus.enable) ? S_IDLE : S_SHIFT;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state; the values are registered below.
  always_comb begin
    w_shift_start_d = (w_state_nxt == S_SHIFT) && (r_state != S_SHIFT);
    w_latch_d       = (w_state_nxt == S_LATCH);
    w_oe_n_d        = (w_state_nxt != S_DISPLAY);
    w_busy_d        = (w_state_nxt != S_IDLE);
    w_frame_done_d  = w_frame_end;
  end

  // Registered panel and handshake outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_shift_start <= 1'b0;
      r_latch       <= 1'b0;
      r_oe_n        <= 1'b1;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_row_addr    <= '0;
      r_bit_plane   <= '0;
    end else begin
      r_shift_start <= w_shift_start_d;
      r_latch       <= w_latch_d;
      r_oe_n        <= w_oe_n_d;
      r_frame_done  <= w_frame_done_d;
      r_busy        <= w_busy_d;
      if (r_state == S_BLANK) begin
        r_row_addr  <= r_row;
        r_bit_plane <= r_plane;
      end
    end
  end

  // Row/plane sequencing, theta tracking and on-time counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_theta   <= '0;
      r_row     <= '0;
      r_plane   <= '0;
      r_restart <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_start || w_frame_end) begin
        r_theta   <= bus.dtheta;
        r_row     <= '0;
        r_plane   <= '0;
        r_restart <= 1'b0;
      end else begin
        if ((r_state != S_IDLE) && (bus.dtheta != r_theta)) r_restart <= 1'b1;
        if (w_disp_end) begin
          if (w_plane_last) begin
            r_plane <= '0;
            r_row   <= r_row + ROW_W'(1);
          end else begin
            r_plane <= r_plane + PL_W'(1);
          end
        end
      end
      // Preloaded outside DISPLAY so the count is ready on entry.
      if (r_state == S_DISPLAY) r_cnt <= r_cnt - CNT_W'(1);
      else                      r_cnt <= w_on_len - CNT_W'(1);
    end
  end

`ifdef HUB75_SCAN_DEADTIME_EN
  // Dead-time cycle counter: two blanked cycles after each latch.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_dead <= 1'b0;
    else        r_dead <= (r_state == S_DEAD) ? ~r_dead : 1'b0;
  end
`endif

  assign bus.shift_start = r_shift_start;
  assign bus.row_addr    = r_row_addr;
  assign bus.bit_plane   = r_bit_plane;
  assign bus.latch       = r_latch;
  assign bus.oe_n        = r_oe_n;
  assign bus.frame_done  = r_frame_done;
  assign bus.busy        = r_busy;
endmodule

// File: doc/hub75_scan_scheduler.md
HUB75_SCAN_SCHEDULER -- requirements
Module: hub75_scan_scheduler

Interface
REQ-001 SHALL have parameter SCAN_RATE, default 32: row addresses per frame (power of 2, >=2).
REQ-002 SHALL have parameter BIT_DEPTH, default 3: bit planes per row (1..8).
REQ-003 SHALL have parameter BASE_ON_CYCLES, default 16: OE-low cycles for bit plane 0 (>=1).
REQ-004 SHALL have parameter THETA_BITS, default 10: width of dtheta.
REQ-005 SHALL have port clk_in, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_in, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port enable, input, 1: permit frame start.
REQ-008 SHALL have port dtheta, input, THETA_BITS: current rotational slice from theta detection.
REQ-009 SHALL have port shift_done, input, 1: one-cycle pulse from the column shifter when a row is shifted.
REQ-010 SHALL have port shift_start, output, 1: one-cycle request to shift row row_addr, plane bit_plane.
REQ-011 SHALL have port row_addr, output, $clog2(SCAN_RATE): HUB75 address lines.
REQ-012 SHALL have port bit_plane, output, $clog2(BIT_DEPTH) (min 1): plane being shifted/displayed.
REQ-013 SHALL have port latch, output, 1: HUB75 latch strobe.
REQ-014 SHALL have port oe_n, output, 1: HUB75 output enable, active-low.
REQ-015 SHALL have port frame_done, output, 1: one-cycle pulse on frame completion or restart.
REQ-016 SHALL have port busy, output, 1: high in any state except IDLE.

Function
REQ-017 SHALL implement states IDLE, SHIFT, BLANK, LATCH, DEAD, DISPLAY.
REQ-018 In IDLE with enable=1, SHALL capture dtheta into theta_q, set row=0, plane=0, pulse shift_start for one cycle, and enter SHIFT.
REQ-019 In SHIFT, SHALL hold oe_n=1 and wait for shift_done; shift_done in the same cycle as shift_start SHALL be ignored.
REQ-020 On shift_done, SHALL enter BLANK for exactly 1 cycle with oe_n=1.
REQ-021 BLANK->LATCH: row_addr/bit_plane outputs update to the shifted row/plane on entry; latch=1 for exactly 1 cycle.
REQ-022 LATCH->DISPLAY (or DEAD, REQ-033): oe_n=0 for exactly BASE_ON_CYCLES<<plane cycles; counter width sufficient for BASE_ON_CYCLES<<(BIT_DEPTH-1).
REQ-023 At DISPLAY end, SHALL advance: plane+1; at plane=BIT_DEPTH-1, plane wraps to 0 and row+1; at row=SCAN_RATE-1 with plane wrap, frame completes.
REQ-024 After advance without frame completion, SHALL pulse shift_start and enter SHIFT in the same cycle oe_n returns to 1.
REQ-025 On frame completion, SHALL pulse frame_done; if enable=1, start a new frame as in REQ-018 in that cycle, else go to IDLE.
REQ-026 dtheta differing from theta_q while busy SHALL set restart_pending; checked only at row wrap (plane wrap) so no row is torn.
REQ-027 At row wrap with restart_pending: row=0, plane=0, recapture theta_q, clear restart_pending, pulse frame_done, continue per REQ-025.
REQ-028 enable deasserting mid-frame SHALL not abort; current frame finishes, then IDLE.
REQ-029 oe_n SHALL be 1 whenever latch=1 and in every state except DISPLAY.
REQ-030 Outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-031 rst_in=1 at any clock edge, including mid-frame, SHALL force IDLE, row=0, plane=0, theta_q=0, restart_pending=0, counters=0.
REQ-032 Reset values: shift_start=0, row_addr=0, bit_plane=0, latch=0, oe_n=1, frame_done=0, busy=0; a shift_done arriving after reset SHALL be ignored.

Configuration
REQ-033 Macro HUB75_SCAN_DEADTIME_EN defined: DEAD state between LATCH and DISPLAY, oe_n=1 for 2 cycles (anti-ghosting); undefined: DEAD absent, DISPLAY starts the cycle after LATCH.

Verification (SCAN_RATE=4, BIT_DEPTH=2, BASE_ON_CYCLES=2, macro undefined unless stated)
REQ-034 enable=1, shift_done 3 cycles after each shift_start -> 8 latch pulses; oe_n-low runs 2,4,2,4,...; rows 0,0,1,1,2,2,3,3; frame_done once.
REQ-035 dtheta 5->6 during row 1 plane 0 -> row 1 plane 1 still displays 4 cycles, then row_addr=0, frame_done pulses, theta_q=6.
REQ-036 rst_in pulsed during DISPLAY of row 2 -> next cycle oe_n=1, row_addr=0, busy=0; a following stale shift_done causes no shift_start.
REQ-037 enable dropped after first shift_start -> full frame completes, then busy=0 and no further shift_start.
REQ-038 With HUB75_SCAN_DEADTIME_EN -> exactly 2 oe_n=1 cycles between each latch and oe_n fall; display lengths unchanged.
REQ-039 Every cycle: assert !(latch && !oe_n), and shift_start never asserts while oe_n=0.
